// File: rtl/bus_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_fetch_sequencer_if
//
// Handshake and bus-control bundle between the LC-3 bus/fetch sequencer and
// the rest of the CPU (execute logic, register file loads, memory).
//
// Signals
//   Run, Continue        : run control levels from the front panel
//   Exec_Req[3:0]        : bus requests from execute logic (3=ALU 2=PC 1=MARMUX 0=MDR)
//   Exec_Done            : execute logic finished the current instruction
//   GateALU/GatePC/
//   GateMARMUX/GateMDR   : one-hot bus gate enables
//   LD_MAR/LD_PC/
//   LD_MDR/LD_IR         : fetch-phase register loads
//   Mem_OE               : memory output enable
//   Exec_Grant[3:0]      : one-hot grant back to execute logic
//   Busy                 : sequencer is not halted
//
// Modports
//   master : the sequencer (drives gates, loads, grants)
//   slave  : the CPU side (drives run control and execute requests)
// -----------------------------------------------------------------------------
interface bus_fetch_sequencer_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Exec_Req;
  logic       Exec_Done;
  logic       GateALU;
  logic       GatePC;
  logic       GateMARMUX;
  logic       GateMDR;
  logic       LD_MAR;
  logic       LD_PC;
  logic       LD_MDR;
  logic       LD_IR;
  logic       Mem_OE;
  logic [3:0] Exec_Grant;
  logic       Busy;

  modport master (
    input  Run, Continue, Exec_Req, Exec_Done,
    output GateALU, GatePC, GateMARMUX, GateMDR,
    output LD_MAR, LD_PC, LD_MDR, LD_IR, Mem_OE,
    output Exec_Grant, Busy
  );

  modport slave (
    output Run, Continue, Exec_Req, Exec_Done,
    input  GateALU, GatePC, GateMARMUX, GateMDR,
    input  LD_MAR, LD_PC, LD_MDR, LD_IR, Mem_OE,
    input  Exec_Grant, Busy
  );
endinterface

// File: rtl/bus_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// bus_fetch_sequencer
//
// Owns the shared 16-bit datapath bus of the LC-3 style CPU. Performs the
// instruction fetch (PC->MAR, memory read into MDR, MDR->IR), then hands the
// bus to the execute logic with fixed-priority arbitration (ALU > PC > MARMUX
// > MDR) until Exec_Done. At most one gate enable is ever high.
//
// Ports
//   Clk    : clock, all state changes on the rising edge
//   Reset  : synchronous, active-high; returns to HALT from any state
//   bus    : bus_fetch_sequencer_if.master (run control, requests, gates,
//            loads, grants, Busy)
//
// Parameters
//   MEM_WAIT : cycles Mem_OE is held before the MDR load (1..15)
//   PAUSE_EN : 1 = wait in PAUSE for a Continue rising edge after each
//              instruction, 0 = go straight to the next fetch
// -----------------------------------------------------------------------------
module bus_fetch_sequencer #(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  bus_fetch_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_EXEC,
    S_PAUSE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       continue_q;

  logic [3:0] gate;   // {ALU, PC, MARMUX, MDR}
  logic [3:0] grant;
  logic       ld_mar, ld_pc, ld_mdr, ld_ir, mem_oe;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_HALT;
      wait_cnt   <= '0;
      continue_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      continue_q <= bus.Continue;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    gate         = 4'b0000;
    grant        = 4'b0000;
    ld_mar       = 1'b0;
    ld_pc        = 1'b0;
    ld_mdr       = 1'b0;
    ld_ir        = 1'b0;
    mem_oe       = 1'b0;

    case (state)
      S_HALT: begin
        if (bus.Run) state_nxt = S_FETCH1;
      end

      S_FETCH1: begin
        gate         = 4'b0100;
        ld_mar       = 1'b1;
        ld_pc        = 1'b1;
        wait_cnt_nxt = WAIT_INIT;
        state_nxt    = S_FETCH2;
      end

      // Memory read: the MDR load lands on the last of the MEM_WAIT cycles.
      S_FETCH2: begin
        mem_oe = 1'b1;
        if (wait_cnt != 4'd0) begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end else begin
          ld_mdr    = 1'b1;
          state_nxt = S_FETCH3;
        end
      end

      S_FETCH3: begin
        gate      = 4'b0001;
        ld_ir     = 1'b1;
        state_nxt = S_EXEC;
      end

      // Grant is combinational from the request so execute logic sees no
      // latency; it is still honoured in the Exec_Done cycle.
      S_EXEC: begin
        if (bus.Exec_Req[3])      grant = 4'b1000;
        else if (bus.Exec_Req[2]) grant = 4'b0100;
        else if (bus.Exec_Req[1]) grant = 4'b0010;
        else if (bus.Exec_Req[0]) grant = 4'b0001;
        gate = grant;
        if (bus.Exec_Done) state_nxt = PAUSE_EN ? S_PAUSE : S_FETCH1;
      end

      // Only a fresh rising edge counts; a level held from before is ignored.
      S_PAUSE: begin
        if (bus.Continue && !continue_q) state_nxt = S_FETCH1;
      end

      default: state_nxt = S_HALT;
    endcase
  end

  assign bus.GateALU    = gate[3];
  assign bus.GatePC     = gate[2];
  assign bus.GateMARMUX = gate[1];
  assign bus.GateMDR    = gate[0];
  assign bus.LD_MAR     = ld_mar;
  assign bus.LD_PC      = ld_pc;
  assign bus.LD_MDR     = ld_mdr;
  assign bus.LD_IR      = ld_ir;
  assign bus.Mem_OE     = mem_oe;
  assign bus.Exec_Grant = grant;
  assign bus.Busy       = (state != S_HALT);

endmodule

// File: doc/bus_fetch_sequencer.md
Name: bus_fetch_sequencer

Overview:
Sequences the shared 16-bit datapath bus for the LC-3 style CPU. Drives the four one-hot bus gate enables (GateALU, GatePC, GateMARMUX, GateMDR) and the fetch-phase register loads. Runs the instruction fetch itself, then arbitrates bus requests from the execute logic until that logic signals completion. Guarantees at most one gate is active in any cycle, so the bus mux never sees a multi-hot select.

Parameters:
MEM_WAIT, 2, number of cycles Mem_OE is held in FETCH2 before the MDR load (range 1..15)
PAUSE_EN, 1, 1 = stop in PAUSE after each instruction until a Continue rising edge; 0 = return straight to FETCH1

Ports:
Clk  input  1  system clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  level; starts execution from HALT
Continue  input  1  level; a rising edge leaves PAUSE
Exec_Req  input  4  bus requests from execute logic, bit3=ALU, bit2=PC, bit1=MARMUX, bit0=MDR
Exec_Done  input  1  execute logic finished the current instruction
GateALU  output  1  bus gate enable
GatePC  output  1  bus gate enable
GateMARMUX  output  1  bus gate enable
GateMDR  output  1  bus gate enable
LD_MAR  output  1  load MAR from bus
LD_PC  output  1  increment/load PC
LD_MDR  output  1  load MDR from memory
LD_IR  output  1  load IR from bus
Mem_OE  output  1  memory output enable
Exec_Grant  output  4  one-hot grant back to the execute logic, same bit order as Exec_Req
Busy  output  1  high in every state except HALT

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-high, Reset.
- Outputs are Moore, decoded from the registered state plus Exec_Req during EXEC only. The edge detector uses a registered Continue_q.
- Reset: state goes to HALT, wait_cnt=0, Continue_q=0. All outputs are 0 in the following cycle. Reset overrides every other input in any state, including mid-fetch.
- HALT: all outputs 0. When Run=1, go to FETCH1.
- FETCH1, one cycle: GatePC=1, LD_MAR=1, LD_PC=1. Next state FETCH2. wait_cnt is loaded with MEM_WAIT-1.
- FETCH2: Mem_OE=1 in every cycle.
  - If wait_cnt!=0, decrement and stay.
  - If wait_cnt==0, LD_MDR=1 this cycle and go to FETCH3.
  - FETCH2 therefore lasts exactly MEM_WAIT cycles, and LD_MDR is high only in the last one.
- FETCH3, one cycle: GateMDR=1, LD_IR=1. Next state EXEC.
- EXEC: fixed-priority arbitration, ALU > PC > MARMUX > MDR.
  - The highest set Exec_Req bit drives the matching Gate* output and Exec_Grant bit.
  - If Exec_Req=0, no gate is driven and Exec_Grant=0.
  - The grant is combinational in the same cycle, with no latency.
  - Exec_Done=1: go to PAUSE if PAUSE_EN=1, otherwise go to FETCH1. The grant is still given in the Exec_Done cycle.
- PAUSE: all outputs 0 except Busy.
  - A rising edge (Continue=1 and Continue_q=0) moves to FETCH1.
  - Continue held high from earlier does not count; it must fall and rise again.
- Run is only sampled in HALT. Dropping Run mid-instruction does not stop the sequence.
- Exec_Req and Exec_Done are ignored outside EXEC.
- One-hot invariant: GateALU+GatePC+GateMARMUX+GateMDR <= 1 in every cycle. Exec_Grant is one-hot or zero, and is zero outside EXEC.
- Latency: the first GatePC appears in the cycle after Run is sampled high in HALT. The fetch takes MEM_WAIT+2 cycles from FETCH1 to the end of FETCH3.

Test Plan:
- Reset for 2 cycles with Run=0 -> all outputs 0 and Busy=0. They stay 0 for 5 more cycles.
- MEM_WAIT=2, Run=1 -> cycle 1: GatePC=LD_MAR=LD_PC=1. Cycles 2-3: Mem_OE=1, with LD_MDR=1 only in cycle 3. Cycle 4: GateMDR=LD_IR=1. Cycle 5: in EXEC.
- In EXEC, Exec_Req=4'b0111 -> GatePC=1 and Exec_Grant=4'b0100. Then 4'b1011 -> GateALU=1 and Exec_Grant=4'b1000. Then 4'b0000 -> all gates 0. Every cycle checked one-hot or zero.
- PAUSE_EN=1, Exec_Done=1 with Continue already held high -> stays in PAUSE. Drive Continue 0 then 1 -> FETCH1 next cycle with GatePC=1.
- Reset asserted in the 2nd FETCH2 cycle (MEM_WAIT=4) -> next cycle in HALT with Mem_OE=0 and LD_MDR never pulsed. A fresh Run gives a full 4-cycle FETCH2.
- PAUSE_EN=0, Exec_Done=1 -> FETCH1 the next cycle. Run dropped to 0 mid-fetch -> sequence completes unaffected.
